// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared, registered ALU.
//
// A request is accepted only in IDLE; the winner's opcode and operands are latched and
// the ALU is driven for exactly one ISSUE cycle. The ALU's registered result is captured
// in CAPTURE, then a DONE cycle follows. At most one operation completes every four cycles.
//
// Ports
//   iclock, iresetn          clock, asynchronous active-low reset
//   ireq0/1, iop0/1          requests (held until granted) and requested opcodes
//   ia0/ib0, ia1/ib1         requester operands
//   ogrant0/1                one-cycle pulse: request accepted, operands latched
//   odone0/1                 one-cycle pulse: oresult/oflags/oerr valid for that requester
//   oresult, oflags, oerr    captured ALU result, status {n,z,p,e,c}, illegal-opcode flag
//   obusy                    high whenever the FSM is not idle
//   oalu_in1/2, oalu_op      ALU operand/opcode drive
//   ialu_out, ialu_psr       ALU result and status, registered one edge after issue
module alu_arbiter #(
  parameter int unsigned     Bits = 12,
  parameter int unsigned     Ops  = 4,
  parameter logic [Ops-1:0]  NOP  = '0
) (
  input  logic            iclock,
  input  logic            iresetn,
  input  logic            ireq0,
  input  logic            ireq1,
  input  logic [Ops-1:0]  iop0,
  input  logic [Ops-1:0]  iop1,
  input  logic [Bits-1:0] ia0,
  input  logic [Bits-1:0] ib0,
  input  logic [Bits-1:0] ia1,
  input  logic [Bits-1:0] ib1,
  output logic            ogrant0,
  output logic            ogrant1,
  output logic            odone0,
  output logic            odone1,
  output logic [Bits-1:0] oresult,
  output logic [4:0]      oflags,
  output logic            oerr,
  output logic            obusy,
  output logic [Bits-1:0] oalu_in1,
  output logic [Bits-1:0] oalu_in2,
  output logic [Ops-1:0]  oalu_op,
  input  logic [Bits-1:0] ialu_out,
  input  logic [4:0]      ialu_psr
);

  // Legal opcodes form the contiguous range ADD(0100) .. ROT(1000).
  localparam logic [Ops-1:0] OpFirst = Ops'(4'b0100);
  localparam logic [Ops-1:0] OpLast  = Ops'(4'b1000);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;     // requester served last (1 = requester 1)
  logic            who_q, who_d;       // requester owning the current operation
  logic            illegal_q, illegal_d;
  logic            grant0_q, grant0_d, grant1_q, grant1_d;
  logic            done0_q, done0_d, done1_q, done1_d;
  logic [Bits-1:0] result_q, result_d;
  logic [4:0]      flags_q, flags_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [Bits-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [Ops-1:0]  aluop_q, aluop_d;

  logic            pick1;
  logic [Ops-1:0]  sel_op;
  logic            sel_legal;

  // Requester 1 wins if it is alone, or if both request and requester 0 was served last.
  assign pick1     = ireq1 & (~ireq0 | ~last_q);
  assign sel_op    = pick1 ? iop1 : iop0;
  assign sel_legal = (sel_op >= OpFirst) && (sel_op <= OpLast);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    who_d     = who_q;
    illegal_d = illegal_q;
    grant0_d  = 1'b0;
    grant1_d  = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    result_d  = result_q;
    flags_d   = flags_q;
    err_d     = err_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    aluop_d   = NOP;

    unique case (state_q)
      StIdle: begin
        if (ireq0 || ireq1) begin
          who_d     = pick1;
          last_d    = pick1;
          illegal_d = ~sel_legal;
          grant0_d  = ~pick1;
          grant1_d  = pick1;
          // Illegal opcodes never reach the ALU, so its operands are left untouched too.
          if (sel_legal) begin
            in1_d   = pick1 ? ia1 : ia0;
            in2_d   = pick1 ? ib1 : ib0;
            aluop_d = sel_op;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        if (illegal_q) begin
          result_d = '0;
          flags_d  = '0;
          err_d    = 1'b1;
        end else begin
          result_d = ialu_out;
          flags_d  = ialu_psr;
          err_d    = 1'b0;
        end
        done0_d = ~who_q;
        done1_d = who_q;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge iclock or negedge iresetn) begin
    if (!iresetn) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;  // favours requester 0 on the first contested grant
      who_q     <= 1'b0;
      illegal_q <= 1'b0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      aluop_q   <= NOP;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      who_q     <= who_d;
      illegal_q <= illegal_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      aluop_q   <= aluop_d;
    end
  end

  assign ogrant0  = grant0_q;
  assign ogrant1  = grant1_q;
  assign odone0   = done0_q;
  assign odone1   = done1_q;
  assign oresult  = result_q;
  assign oflags   = flags_q;
  assign oerr     = err_q;
  assign obusy    = busy_q;
  assign oalu_in1 = in1_q;
  assign oalu_in2 = in2_q;
  assign oalu_op  = aluop_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model.
module tb_alu_arbiter;

  logic        iclock = 1'b0;
  logic        iresetn;
  logic        ireq0, ireq1;
  logic [3:0]  iop0, iop1;
  logic [11:0] ia0, ib0, ia1, ib1;
  logic        ogrant0, ogrant1, odone0, odone1;
  logic [11:0] oresult;
  logic [4:0]  oflags;
  logic        oerr, obusy;
  logic [11:0] oalu_in1, oalu_in2;
  logic [3:0]  oalu_op;
  logic [11:0] ialu_out;
  logic [4:0]  ialu_psr;

  int nchk = 0;
  int nerr = 0;

  always #5 iclock = ~iclock;

  alu_arbiter #(.Bits(12), .Ops(4), .NOP(4'b0000)) dut (
    .iclock   (iclock),
    .iresetn  (iresetn),
    .ireq0    (ireq0),
    .ireq1    (ireq1),
    .iop0     (iop0),
    .iop1     (iop1),
    .ia0      (ia0),
    .ib0      (ib0),
    .ia1      (ia1),
    .ib1      (ib1),
    .ogrant0  (ogrant0),
    .ogrant1  (ogrant1),
    .odone0   (odone0),
    .odone1   (odone1),
    .oresult  (oresult),
    .oflags   (oflags),
    .oerr     (oerr),
    .obusy    (obusy),
    .oalu_in1 (oalu_in1),
    .oalu_in2 (oalu_in2),
    .oalu_op  (oalu_op),
    .ialu_out (ialu_out),
    .ialu_psr (ialu_psr)
  );

  // ALU model: registers result one edge after a non-NOP opcode, holds otherwise.
  // Status {n,z,p,e,c}; c is the carry/overflow above bit 11.
  always @(posedge iclock) begin
    logic [23:0] wide;
    if (oalu_op != 4'b0000) begin
      case (oalu_op)
        4'b0100: wide = {12'b0, oalu_in1} + {12'b0, oalu_in2};
        4'b0101: wide = {12'b0, oalu_in1} * {12'b0, oalu_in2};
        default: wide = {12'b0, oalu_in1};
      endcase
      ialu_out <= wide[11:0];
      ialu_psr <= {wide[11], wide[11:0] == 12'h000, !wide[11] && wide[11:0] != 12'h000,
                   1'b0, |wide[23:12]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction from the first edge after the request is presented.
  task automatic txn(input string tag, input int who, input logic [3:0] exp_op,
                     input logic [11:0] exp_res, input logic [4:0] exp_flg,
                     input logic exp_err, input logic hold, input logic raise1);
    int n = 0;
    do begin
      @(posedge iclock); #1;
      n++;
    end while (!(ogrant0 || ogrant1) && n < 8);
    // E0
    check({tag, ".wait"}, n, 1);
    check({tag, ".grant0"}, ogrant0, who == 0);
    check({tag, ".grant1"}, ogrant1, who == 1);
    check({tag, ".issue_op"}, oalu_op, exp_op);
    check({tag, ".busy_e0"}, obusy, 1'b1);
    if (!hold) begin
      if (who == 0) ireq0 = 1'b0;
      else ireq1 = 1'b0;
    end
    if (raise1) ireq1 = 1'b1;
    // E1
    @(posedge iclock); #1;
    check({tag, ".op_nop_e1"}, oalu_op, 4'b0000);
    check({tag, ".grants_e1"}, {ogrant0, ogrant1}, 2'b00);
    // E2
    @(posedge iclock); #1;
    check({tag, ".done0"}, odone0, who == 0);
    check({tag, ".done1"}, odone1, who == 1);
    check({tag, ".result"}, oresult, exp_res);
    check({tag, ".flags"}, oflags, exp_flg);
    check({tag, ".err"}, oerr, exp_err);
    check({tag, ".grants_e2"}, {ogrant0, ogrant1}, 2'b00);
    // E3: DONE must not accept a pending request
    @(posedge iclock); #1;
    check({tag, ".dones_e3"}, {odone0, odone1}, 2'b00);
    check({tag, ".busy_e3"}, obusy, 1'b0);
    check({tag, ".grants_e3"}, {ogrant0, ogrant1}, 2'b00);
    check({tag, ".err_hold"}, oerr, exp_err);
    check({tag, ".res_hold"}, oresult, exp_res);
  endtask

  initial begin
    iresetn = 1'b0;
    ireq0 = 1'b0; ireq1 = 1'b0;
    iop0 = 4'h0; iop1 = 4'h0;
    ia0 = '0; ib0 = '0; ia1 = '0; ib1 = '0;
    #12;
    check("rst.busy", obusy, 1'b0);
    check("rst.pulses", {ogrant0, ogrant1, odone0, odone1}, 4'h0);
    check("rst.result", oresult, 12'h000);
    check("rst.flags", oflags, 5'h00);
    check("rst.err", oerr, 1'b0);
    check("rst.aluop", oalu_op, 4'h0);
    check("rst.in", {oalu_in1, oalu_in2}, 24'h0);
    iresetn = 1'b1;

    // ADD 0FF+001 from requester 0
    ia0 = 12'h0FF; ib0 = 12'h001; iop0 = 4'b0100; ireq0 = 1'b1;
    txn("add0", 0, 4'b0100, 12'h100, 5'b00100, 1'b0, 1'b0, 1'b0);

    // ADD FFF+001 from requester 1: wraps to zero with carry
    ia1 = 12'hFFF; ib1 = 12'h001; iop1 = 4'b0100; ireq1 = 1'b1;
    txn("add1", 1, 4'b0100, 12'h000, 5'b01001, 1'b0, 1'b0, 1'b0);

    // Illegal opcode: ALU never driven, error completion
    iop0 = 4'b1111; ireq0 = 1'b1;
    txn("ill", 0, 4'b0000, 12'h000, 5'b00000, 1'b1, 1'b0, 1'b0);

    // Requester 1 arrives while requester 0 is busy; its grant follows DONE
    ia0 = 12'h001; ib0 = 12'h002; iop0 = 4'b0100; ireq0 = 1'b1;
    ia1 = 12'h010; ib1 = 12'h010; iop1 = 4'b0101;
    txn("busy0", 0, 4'b0100, 12'h003, 5'b00100, 1'b0, 1'b0, 1'b1);
    txn("mul1", 1, 4'b0101, 12'h100, 5'b00100, 1'b0, 1'b0, 1'b0);

    // Reset during CAPTURE aborts with no done pulse
    ia0 = 12'h0FF; ib0 = 12'h001; iop0 = 4'b0100; ireq0 = 1'b1;
    @(posedge iclock); #1;
    check("rstcap.grant0", ogrant0, 1'b1);
    ireq0 = 1'b0;
    @(posedge iclock); #3;
    iresetn = 1'b0;
    #1;
    check("rstcap.busy", obusy, 1'b0);
    check("rstcap.result", oresult, 12'h000);
    check("rstcap.flags", oflags, 5'h00);
    check("rstcap.in", {oalu_in1, oalu_in2}, 24'h0);
    check("rstcap.aluop", oalu_op, 4'h0);
    @(posedge iclock); #1;
    check("rstcap.nodone", {odone0, odone1, ogrant0, ogrant1}, 4'h0);
    iresetn = 1'b1;
    @(posedge iclock); #1;
    check("rstcap.nodone2", {odone0, odone1}, 2'b00);
    check("rstcap.idle", obusy, 1'b0);

    // Both held from reset: 0, 1, 0
    ia0 = 12'h001; ib0 = 12'h002; iop0 = 4'b0100;
    ia1 = 12'h010; ib1 = 12'h020; iop1 = 4'b0100;
    ireq0 = 1'b1; ireq1 = 1'b1;
    txn("rr0", 0, 4'b0100, 12'h003, 5'b00100, 1'b0, 1'b1, 1'b0);
    txn("rr1", 1, 4'b0100, 12'h030, 5'b00100, 1'b0, 1'b1, 1'b0);
    txn("rr2", 0, 4'b0100, 12'h003, 5'b00100, 1'b0, 1'b0, 1'b0);
    ireq1 = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
